// File: rtl/main_memory_responder.sv
// Backing word memory for the direct-mapped cache: one request at a time on a req/ack
// handshake, answered after a fixed LATENCY so hit/miss timing is visible in simulation.
module main_memory_responder #(
  parameter int unsigned        ADDR_W   = 10,
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        LATENCY  = 3,
  parameter logic [DATA_W-1:0]  INIT_XOR = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("main_memory_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem_rd [DEPTH];
  logic                wr_en;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          count_d = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            if (!mem_we) rdata_d = mem_rd[mem_addr];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (count_q == 4'd1) begin
          state_d = RESP;
          count_d = '0;
          if (!we_q) rdata_d = mem_rd[addr_q];
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Write commits on the edge leaving RESP; reset forces IDLE, so an aborted write never lands.
  assign wr_en = (state_q == RESP) && we_q;

  // One register per word so each can carry its own power-up value; not touched by reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    localparam logic [ADDR_W-1:0] WADDR = ADDR_W'(g);
    localparam logic [DATA_W-1:0] WINIT = DATA_W'(WADDR[7:0]) ^ INIT_XOR;
    logic [DATA_W-1:0] word_q = WINIT;
    logic [DATA_W-1:0] word_d;
    always_comb begin
      word_d = word_q;
      if (wr_en && (addr_q == WADDR)) word_d = wdata_q;
    end
    always_ff @(posedge clock) word_q <= word_d;
    assign mem_rd[g] = word_q;
  end

  assign mem_busy  = busy_q;
  assign mem_ack   = ack_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: drivers push expected ack cycle and rdata; per-DUT monitors pop on mem_ack.
module tb_main_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       req0, we0, busy0, ack0;
  logic [9:0] addr0;
  logic [7:0] wdata0, rdata0;
  logic       req1, we1, busy1, ack1;
  logic [9:0] addr1;
  logic [7:0] wdata1, rdata1;

  main_memory_responder #(.ADDR_W(10), .DATA_W(8), .LATENCY(3), .INIT_XOR(8'hA5)) dut (
    .clock(clock), .reset_n(reset_n), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_busy(busy0), .mem_ack(ack0), .mem_rdata(rdata0));

  main_memory_responder #(.ADDR_W(10), .DATA_W(8), .LATENCY(1), .INIT_XOR(8'hA5)) dut1 (
    .clock(clock), .reset_n(reset_n), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_busy(busy1), .mem_ack(ack1), .mem_rdata(rdata1));

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0]  rd;
    logic [31:0] cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] ref_mem [1024];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (ack0 === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL lat3 unexpected ack: got ack=1 expected no ack (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("lat3 ack cycle", cyc, e.cyc);
        check("lat3 rdata", {24'd0, rdata0}, {24'd0, e.rd});
      end
    end
  end

  always @(negedge clock) begin
    if (ack1 === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL lat1 unexpected ack: got ack=1 expected no ack (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("lat1 ack cycle", cyc, e.cyc);
        check("lat1 rdata", {24'd0, rdata1}, {24'd0, e.rd});
      end
    end
  end

  // Present a request and wait for the edge where busy rises (the accept edge).
  task automatic issue(input bit s, input logic we, input logic [9:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input bit push, input bit hold,
                       output int unsigned acc);
    logic b0;
    bit   done;
    done = 1'b0;
    acc  = 0;
    if (!s) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; b0 = busy0; end
    else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; b0 = busy1; end
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clock); #1;
      if (!b0 && (s ? busy1 : busy0)) begin
        done = 1'b1;
        acc  = cyc;
      end
      b0 = s ? busy1 : busy0;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL accept timeout: dut%0d got no accept expected accept within 60 cycles", s);
    end else if (push) begin
      if (!s) q0.push_back('{rd: exp_rd, cyc: acc + 2});
      else    q1.push_back('{rd: exp_rd, cyc: acc});
    end
    if (!hold) begin
      if (!s) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit s, output int unsigned n);
    bit done;
    done = 1'b0;
    n    = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (s ? busy1 : busy0) begin
        n++;
        @(posedge clock); #1;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL idle timeout: dut%0d got busy expected idle within 60 cycles", s);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc, a1, a2, n;
    logic [7:0]  last1, exp_rd, wd;
    logic [9:0]  ad;
    logic        we;

    for (int i = 0; i < 1024; i++) begin
      ad = 10'(i);
      ref_mem[i] = ad[7:0] ^ 8'hA5;
    end
    reset_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", {31'd0, busy0}, 32'd0);
    check("reset ack", {31'd0, ack0}, 32'd0);
    check("reset rdata", {24'd0, rdata0}, 32'd0);
    check("reset lat1 busy", {31'd0, busy1}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Power-up read at tag FF idx 1, busy for exactly LATENCY cycles
    issue(0, 1'b0, 10'h3FD, 8'h00, 8'h58, 1, 0, acc);
    wait_idle(0, n);
    check("busy cycles", n, 32'd3);

    // Write then read back, neighbour untouched
    issue(0, 1'b1, 10'h004, 8'h01, 8'h58, 1, 0, acc);
    issue(0, 1'b0, 10'h004, 8'h00, 8'h01, 1, 0, acc);
    issue(0, 1'b0, 10'h005, 8'h00, 8'hA0, 1, 0, acc);

    // Held request: next accept one idle cycle after the ack; address changed while busy
    issue(0, 1'b0, 10'h120, 8'h00, 8'h85, 1, 1, a1);
    issue(0, 1'b0, 10'h2AB, 8'h00, 8'h0E, 1, 0, a2);
    check("held accept spacing", a2 - a1, 32'd4);
    wait_idle(0, n);
    @(posedge clock); #1;

    // Abort a write during WAIT; reset must clear outputs without a clock edge
    issue(0, 1'b1, 10'h010, 8'h77, 8'h00, 0, 0, acc);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("async reset busy", {31'd0, busy0}, 32'd0);
    check("async reset ack", {31'd0, ack0}, 32'd0);
    check("async reset rdata", {24'd0, rdata0}, 32'd0);
    @(negedge clock) reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    issue(0, 1'b0, 10'h010, 8'h00, 8'hB5, 1, 0, acc);
    issue(0, 1'b1, 10'h3FF, 8'h3C, 8'hB5, 1, 0, acc);
    wait_idle(0, n);

    // LATENCY=1 build: directed then random traffic against a reference array
    issue(1, 1'b0, 10'h3FD, 8'h00, 8'h58, 1, 0, acc);
    last1 = 8'h58;
    issue(1, 1'b1, 10'h3FD, 8'hC3, last1, 1, 0, acc);
    ref_mem[10'h3FD] = 8'hC3;
    issue(1, 1'b0, 10'h3FD, 8'h00, 8'hC3, 1, 0, acc);
    last1 = 8'hC3;
    for (int t = 0; t < 1000; t++) begin
      we = 1'($urandom_range(0, 1));
      ad = 10'($urandom_range(0, 1023));
      if (t % 4 == 0) ad = 10'($urandom_range(0, 7));
      wd = 8'($urandom);
      if (we) begin
        exp_rd = last1;
        ref_mem[ad] = wd;
      end else begin
        exp_rd = ref_mem[ad];
        last1  = exp_rd;
      end
      issue(1, we, ad, wd, exp_rd, 1, 0, acc);
    end
    wait_idle(1, n);

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clock);
    #1;
    check("lat3 pending acks", q0.size(), 32'd0);
    check("lat1 pending acks", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
